// File: rtl/systolic_ctrl.sv
// Operand buffers and FSM that feed an N x N output-stationary systolic array.
// Once start is sampled, the array holds A*B when the one-cycle done pulse appears, 3N cycles after the start cycle.
module systolic_ctrl #(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic                 wr_sel,
    input  logic [$clog2(N)-1:0] wr_row,
    input  logic [$clog2(N)-1:0] wr_col,
    input  logic [W-1:0]         wr_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 wr_err,
    output logic                 pe_clr,
    output logic [N*W-1:0]       west_bus,
    output logic [N*W-1:0]       north_bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        FEED  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int             TW     = $clog2(3 * N);
    localparam logic [TW-1:0]  T_LAST = TW'(3 * N - 3);

    state_e                 state_q, state_d;
    logic [TW-1:0]          t_q, t_d;
    logic                   feed_d;
    logic [W-1:0]           a_q [N][N];
    logic [W-1:0]           b_q [N][N];
    logic [N-1:0][W-1:0]    west_q, west_d;
    logic [N-1:0][W-1:0]    north_q, north_d;
    logic                   wr_err_q;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        feed_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = FEED;
                t_d     = '0;
                feed_d  = 1'b1;
            end
            FEED: begin
                if (t_q == T_LAST) begin
                    state_d = DONE;
                    t_d     = '0;
                end else begin
                    t_d    = t_q + TW'(1);
                    feed_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Lane registers are loaded with the slot that becomes current on this edge;
    // element k of row/column i enters at slot i+k, giving the diagonal skew.
    always_comb begin
        west_d  = '0;
        north_d = '0;
        if (feed_d) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    if (int'(t_d) == i + k) begin
                        west_d[i]  = a_q[i][k];
                        north_d[i] = b_q[k][i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            t_q      <= '0;
            west_q   <= '0;
            north_q  <= '0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            west_q   <= west_d;
            north_q  <= north_d;
            wr_err_q <= wr_en && (state_q != IDLE);
        end
    end

    // Writes land only while idle, so a write in the start cycle is seen by that run.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_q[i][j] <= '0;
                    b_q[i][j] <= '0;
                end
            end
        end else if (wr_en && (state_q == IDLE)) begin
            if (wr_sel) begin
                b_q[wr_row][wr_col] <= wr_data;
            end else begin
                a_q[wr_row][wr_col] <= wr_data;
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign pe_clr    = (state_q == CLEAR);
    assign wr_err    = wr_err_q;
    assign west_bus  = west_q;
    assign north_bus = north_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: behavioural PE grid driven by the lane buses, checked against a plain matrix product.
module tb_systolic_ctrl;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int RW = $clog2(N);

    logic           clk = 1'b0;
    logic           rst;
    logic           wr_en;
    logic           wr_sel;
    logic [RW-1:0]  wr_row;
    logic [RW-1:0]  wr_col;
    logic [W-1:0]   wr_data;
    logic           start;
    logic           busy;
    logic           done;
    logic           wr_err;
    logic           pe_clr;
    logic [N*W-1:0] west_bus;
    logic [N*W-1:0] north_bus;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] ma [N][N];
    logic [W-1:0] mb [N][N];
    logic [W-1:0] ec [N][N];
    logic [31:0]  w3_mask;
    int           done_cnt;

    logic [W-1:0] pe_acc [N][N];
    logic [W-1:0] pe_w   [N][N];
    logic [W-1:0] pe_n   [N][N];

    systolic_ctrl #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_data   (wr_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .wr_err    (wr_err),
        .pe_clr    (pe_clr),
        .west_bus  (west_bus),
        .north_bus (north_bus)
    );

    always #5 clk = ~clk;

    // Output-stationary PE grid: multiply-accumulate, pass west->east and north->south.
    always @(posedge clk) begin
        logic [W-1:0] win;
        logic [W-1:0] nin;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == 0) win = west_bus[i*W +: W];
                else        win = pe_w[i][j-1];
                if (i == 0) nin = north_bus[j*W +: W];
                else        nin = pe_n[i-1][j];
                if (pe_clr) begin
                    pe_acc[i][j] <= '0;
                    pe_w[i][j]   <= '0;
                    pe_n[i][j]   <= '0;
                end else begin
                    pe_acc[i][j] <= pe_acc[i][j] + win * nin;
                    pe_w[i][j]   <= win;
                    pe_n[i][j]   <= nin;
                end
            end
        end
    end

    task automatic wr(input logic sel, input int r, input int c, input logic [W-1:0] d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_row  = r[RW-1:0];
        wr_col  = c[RW-1:0];
        wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (sel) mb[r][c] = d;
        else     ma[r][c] = d;
    endtask

    task automatic load_mats();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                wr(1'b0, r, c, ma[r][c]);
                wr(1'b1, r, c, mb[r][c]);
            end
    endtask

    task automatic zero_model();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = '0;
                mb[r][c] = '0;
            end
    endtask

    // One run from start; optional extra start pulse, busy write or reset at cycle k.
    task automatic do_run(input int pulse_k, input int wr_k, input int rst_k);
        int             nn;
        int             t;
        int             d;
        logic [W-1:0]   s;
        logic [N*W-1:0] ew;
        logic [N*W-1:0] en;
        nn = 3 * N;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = '0;
                for (int k = 0; k < N; k++) s = s + ma[i][k] * mb[k][j];
                ec[i][j] = s;
            end
        done_cnt = 0;
        w3_mask  = '0;
        start    = 1'b1;
        for (int k = 1; k <= nn + 2; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            wr_en = 1'b0;
            if (rst_k >= 0 && k == rst_k + 1) begin
                rst = 1'b0;
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
                total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", done); end
                total++; if (west_bus !== '0 || north_bus !== '0) begin
                    bad++; $display("FAIL abort_lanes west=%h north=%h exp=0", west_bus, north_bus);
                end
                zero_model();
                return;
            end
            ew = '0;
            en = '0;
            if (k >= 2 && k <= nn - 1) begin
                t = k - 2;
                for (int i = 0; i < N; i++) begin
                    d = t - i;
                    if (d >= 0 && d < N) begin
                        ew[i*W +: W] = ma[i][d];
                        en[i*W +: W] = mb[d][i];
                    end
                end
                if (west_bus[(N-1)*W +: W] != '0) w3_mask[t] = 1'b1;
            end
            total++; if (west_bus !== ew) begin bad++; $display("FAIL west_bus k=%0d got=%h exp=%h", k, west_bus, ew); end
            total++; if (north_bus !== en) begin bad++; $display("FAIL north_bus k=%0d got=%h exp=%h", k, north_bus, en); end
            total++; if (busy !== (k <= nn)) begin bad++; $display("FAIL busy k=%0d got=%b exp=%b", k, busy, (k <= nn)); end
            if (done === 1'b1) done_cnt++;
            total++; if (done !== (k == nn)) begin bad++; $display("FAIL done k=%0d got=%b exp=%b", k, done, (k == nn)); end
            total++; if (pe_clr !== (k == 1)) begin bad++; $display("FAIL pe_clr k=%0d got=%b exp=%b", k, pe_clr, (k == 1)); end
            total++; if (wr_err !== (wr_k >= 0 && k == wr_k + 1)) begin
                bad++; $display("FAIL wr_err k=%0d got=%b", k, wr_err);
            end
            if (k == nn) begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        total++;
                        if (pe_acc[i][j] !== ec[i][j]) begin
                            bad++; $display("FAIL pe(%0d,%0d) got=%h exp=%h", i, j, pe_acc[i][j], ec[i][j]);
                        end
                    end
            end
            if (k == pulse_k) start = 1'b1;
            if (k == wr_k) begin
                wr_en   = 1'b1;
                wr_sel  = 1'b0;
                wr_row  = '0;
                wr_col  = '0;
                wr_data = 16'd5;
            end
            if (k == rst_k) rst = 1'b1;
        end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL done_count got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1;
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = 16'h7;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
        total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL rst_wr_err got=%b exp=0", wr_err); end
        total++; if (pe_clr !== 1'b0) begin bad++; $display("FAIL rst_pe_clr got=%b exp=0", pe_clr); end
        total++; if (west_bus !== '0) begin bad++; $display("FAIL rst_west got=%h exp=0", west_bus); end
        total++; if (north_bus !== '0) begin bad++; $display("FAIL rst_north got=%h exp=0", north_bus); end
        rst = 1'b0; start = 1'b0; wr_en = 1'b0;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_start_prio got=%b exp=0", busy); end
        // A must still be all zero: the write under reset was dropped.
        zero_model();
        for (int r = 0; r < N; r++) wr(1'b1, r, r, 16'd1);
        do_run(-1, -1, -1);
    endtask

    task automatic test_identity();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = (r == c) ? 16'd1 : 16'd0;
                mb[r][c] = W'(4 * r + c + 1);
            end
        load_mats();
        do_run(-1, -1, -1);
        total++; if (pe_acc[2][3] !== 16'd12) begin bad++; $display("FAIL ident_pe23 got=%0d exp=12", pe_acc[2][3]); end
    endtask

    task automatic test_all_twos();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = 16'd2;
                mb[r][c] = 16'd2;
            end
        load_mats();
        do_run(-1, -1, -1);
        total++; if (pe_acc[3][0] !== 16'd16) begin bad++; $display("FAIL twos_pe30 got=%0d exp=16", pe_acc[3][0]); end
        total++; if (w3_mask !== 32'h78) begin bad++; $display("FAIL twos_lane3 got=%h exp=78", w3_mask); end
    endtask

    task automatic test_wrap();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = 16'h0100;
                mb[r][c] = 16'h0100;
            end
        load_mats();
        do_run(-1, -1, -1);
        total++; if (pe_acc[1][2] !== 16'h0000) begin bad++; $display("FAIL wrap_pe12 got=%h exp=0", pe_acc[1][2]); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3; n++) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    ma[r][c] = W'($urandom);
                    mb[r][c] = W'($urandom);
                end
            load_mats();
            do_run(-1, -1, -1);
        end
    endtask

    task automatic test_start_ignored();
        do_run(4, -1, -1);
    endtask

    task automatic test_busy_write();
        wr(1'b0, 0, 0, 16'd9);
        do_run(-1, 5, -1);
        do_run(-1, -1, -1);
    endtask

    task automatic test_back_to_back();
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd2; wr_col = 2'd1;
        wr_data = W'($urandom_range(1, 65535));
        ma[2][1] = wr_data;
        do_run(-1, -1, -1);
        do_run(-1, -1, -1);
    endtask

    task automatic test_rst_abort();
        do_run(-1, -1, 6);
        for (int n = 0; n < 2; n++) begin
            @(posedge clk); #1;
            total++; if (done !== 1'b0 || busy !== 1'b0) begin
                bad++; $display("FAIL abort_idle done=%b busy=%b exp=0", done, busy);
            end
        end
        for (int r = 0; r < N; r++) wr(1'b1, r, r, 16'd1);
        do_run(-1, -1, -1);
        total++; if (pe_acc[1][1] !== 16'd0) begin bad++; $display("FAIL abort_a11 got=%h exp=0", pe_acc[1][1]); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_sel = 1'b0;
        wr_row = '0; wr_col = '0; wr_data = '0;
        zero_model();
        test_reset();
        test_identity();
        test_all_twos();
        test_wrap();
        test_random();
        test_start_ignored();
        test_busy_write();
        test_back_to_back();
        test_rst_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001: Parameter N, default 4, SHALL be the array dimension (N x N PEs, N a power of two, 2..8).
REQ-002: Parameter W, default 16, SHALL be the operand and lane width in bits.
REQ-003: clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004: rst  input  1  SHALL be the reset; reset is synchronous and active-high.
REQ-005: wr_en  input  1  SHALL be the operand buffer write strobe.
REQ-006: wr_sel  input  1  SHALL select the buffer to write: 0 = matrix A, 1 = matrix B.
REQ-007: wr_row, wr_col  input  log2(N) each  SHALL be the element index of the write.
REQ-008: wr_data  input  W  SHALL be the element value.
REQ-009: start  input  1  SHALL be the one-cycle request to run a multiply.
REQ-010: busy  output  1  SHALL be high whenever the FSM is not IDLE.
REQ-011: done  output  1  SHALL be a one-cycle pulse marking results valid in the array.
REQ-012: wr_err  output  1  SHALL be a one-cycle pulse flagging a rejected write.
REQ-013: pe_clr  output  1  SHALL drive the rst input of every PE to clear accumulators and lane registers.
REQ-014: west_bus  output  N*W  SHALL carry lane i in bits [i*W +: W], feeding the west input of row i, column 0.
REQ-015: north_bus  output  N*W  SHALL carry lane j in bits [j*W +: W], feeding the north input of row 0, column j.

Function
REQ-016: The block SHALL hold two N x N W-bit buffers, A and B, written only through the write port.
REQ-017: In IDLE, wr_en SHALL write wr_data to A[wr_row][wr_col] (wr_sel=0) or B[wr_row][wr_col] (wr_sel=1) at the clock edge.
REQ-018: When busy=1, wr_en SHALL leave the buffers unchanged and SHALL pulse wr_err for the following cycle.
REQ-019: The FSM SHALL have states IDLE, CLEAR, FEED and DONE.
REQ-020: IDLE -> CLEAR SHALL occur on start=1; start in any other state SHALL be ignored and not queued.
REQ-021: CLEAR SHALL last exactly one cycle with pe_clr=1, then go to FEED with feed counter t=0.
REQ-022: FEED SHALL last exactly 3N-2 cycles, t = 0..3N-3, then go to DONE.
REQ-023: During FEED cycle t, west lane i SHALL equal A[i][t-i] when 0 <= t-i < N, else 0.
REQ-024: During FEED cycle t, north lane j SHALL equal B[t-j][j] when 0 <= t-j < N, else 0.
REQ-025: Lanes SHALL be register outputs; they SHALL be 0 in IDLE, CLEAR and DONE.
REQ-026: DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-027: After done, PE(i,j) SHALL hold sum over k of A[i][k]*B[k][j], truncated to W bits (mod 2^W); the block SHALL not alter the PEs until the next CLEAR.
REQ-028: A write and start in the same IDLE cycle SHALL both be accepted, and the written element SHALL be used by that run.
REQ-029: Start-to-done latency SHALL be 3N cycles (1 CLEAR + 3N-2 FEED + 1 cycle to DONE); for N=4, done is high 12 cycles after the start edge.
REQ-030: Buffers SHALL retain contents across runs; a second start without writes SHALL reproduce identical results.

Reset
REQ-031: With rst=1 at a clock edge, state SHALL go to IDLE and busy, done, wr_err and pe_clr SHALL be 0; all lanes SHALL be 0; all buffer entries SHALL be 0.
REQ-032: rst SHALL take priority over start and wr_en in the same cycle.
REQ-033: rst during CLEAR, FEED or DONE SHALL abort the run with no done pulse; PE contents are undefined until the next CLEAR.

Verification
REQ-034: N=4, A=identity, B[r][c]=4r+c+1, start -> done 12 cycles later; PE(i,j)=4i+j+1.
REQ-035: N=4, A and B all 2 -> every PE = 16; west lane 3 nonzero only for FEED t=3..6.
REQ-036: N=4, A and B all 16'h0100 -> every PE = 16'h0000 (wrap-around).
REQ-037: start pulsed again at FEED t=2 -> ignored; exactly one done, still 12 cycles after the first start.
REQ-038: wr_en with A[0][0]=5 while busy -> wr_err=1 next cycle; A[0][0] unchanged; results unchanged.
REQ-039: rst at FEED t=4 -> next cycle busy=0 and lanes=0, no done; A[1][1]=0 when read back via a rerun with B=identity.
